// File: rtl/axis_frame_driver.sv
`default_nettype none
// ============================================================================
//  Module   : axis_frame_driver
//  Purpose  : Sends one frame of INP_DEPTH words from a local transmit buffer
//             on an AXI-Stream master port. It then collects OUT_DEPTH result
//             words from an AXI-Stream slave port into a receive buffer.
//             Software loads the transmit buffer, pulses start, waits for done
//             and reads the results back through res_addr/res_data.
//
//  Ports    : axi_clk, axi_reset_n     clock, synchronous active-low reset
//             ld_valid/ld_addr/ld_data  transmit buffer write port
//             start                     run one frame
//             busy, done                frame status
//             m_axis_*                  frame output stream
//             s_axis_*                  result input stream
//             res_addr/res_data         combinational result readback
//             m_axis_last               end-of-frame marker (optional)
//
//  Config   : define AXIS_FRAME_DRIVER_LAST_EN to add the m_axis_last output.
//
//  Revision : 1.0  initial release
// ============================================================================
module axis_frame_driver #(
  parameter int INP_DEPTH         = 8,
  parameter int OUT_DEPTH         = 2,
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_DATA_WIDTH = INPUT_DATA_WIDTH + $clog2(INP_DEPTH)
) (
  input  logic                                                axi_clk,
  input  logic                                                axi_reset_n,
  input  logic                                                ld_valid,
  input  logic [((INP_DEPTH > 1) ? $clog2(INP_DEPTH) : 1)-1:0] ld_addr,
  input  logic [INPUT_DATA_WIDTH-1:0]                         ld_data,
  input  logic                                                start,
  output logic                                                busy,
  output logic                                                done,
  output logic                                                m_axis_valid,
  output logic [INPUT_DATA_WIDTH-1:0]                         m_axis_data,
`ifdef AXIS_FRAME_DRIVER_LAST_EN
  output logic                                                m_axis_last,
`endif
  input  logic                                                m_axis_ready,
  input  logic                                                s_axis_valid,
  input  logic [OUTPUT_DATA_WIDTH-1:0]                        s_axis_data,
  output logic                                                s_axis_ready,
  input  logic [((OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1)-1:0] res_addr,
  output logic [OUTPUT_DATA_WIDTH-1:0]                        res_data
);

  localparam int TX_AW = (INP_DEPTH > 1) ? $clog2(INP_DEPTH) : 1;
  localparam int RX_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  localparam logic [TX_AW-1:0] C_TX_LAST = TX_AW'(INP_DEPTH - 1);
  localparam logic [RX_AW-1:0] C_RX_LAST = RX_AW'(OUT_DEPTH - 1);

  // Depths widened by one bit so that the range checks also work when the
  // depth is an exact power of two.
  localparam logic [TX_AW:0] C_TX_DEPTH = (TX_AW + 1)'(INP_DEPTH);
  localparam logic [RX_AW:0] C_RX_DEPTH = (RX_AW + 1)'(OUT_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                   state_q,  state_d;
  logic [TX_AW-1:0]             tx_idx_q, tx_idx_d;
  logic [RX_AW-1:0]             rx_idx_q, rx_idx_d;
  logic [INPUT_DATA_WIDTH-1:0]  tx_buf_q [INP_DEPTH];
  logic [INPUT_DATA_WIDTH-1:0]  tx_buf_d [INP_DEPTH];
  logic [OUTPUT_DATA_WIDTH-1:0] rx_buf_q [OUT_DEPTH];
  logic [OUTPUT_DATA_WIDTH-1:0] rx_buf_d [OUT_DEPTH];

  logic w_accepting;   // IDLE or DONE: loads and start are honoured
  logic w_tx_beat;
  logic w_rx_beat;
  logic w_ld_in_range;
  logic w_res_in_range;

  assign w_accepting    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign w_tx_beat      = (state_q == S_SEND) && m_axis_ready;
  assign w_rx_beat      = (state_q == S_RECV) && s_axis_valid;
  assign w_ld_in_range  = ({1'b0, ld_addr} < C_TX_DEPTH);
  assign w_res_in_range = ({1'b0, res_addr} < C_RX_DEPTH);

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    tx_idx_d = tx_idx_q;
    rx_idx_d = rx_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SEND;
          tx_idx_d = '0;
          rx_idx_d = '0;
        end
      end
      S_SEND: begin
        if (w_tx_beat) begin
          if (tx_idx_q == C_TX_LAST) begin
            state_d  = S_RECV;
            // Parked at zero so the read index never points past the buffer.
            tx_idx_d = '0;
          end else begin
            tx_idx_d = tx_idx_q + TX_AW'(1);
          end
        end
      end
      S_RECV: begin
        if (w_rx_beat) begin
          if (rx_idx_q == C_RX_LAST) begin
            state_d  = S_DONE;
            rx_idx_d = '0;
          end else begin
            rx_idx_d = rx_idx_q + RX_AW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state_q  <= S_IDLE;
      tx_idx_q <= '0;
      rx_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_idx_q <= tx_idx_d;
      rx_idx_q <= rx_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit buffer: writable only while no frame is in flight. A load in the
  // same cycle as start lands before the first beat is read, so it is part of
  // the frame. Contents deliberately survive reset.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < INP_DEPTH; i++) begin
      tx_buf_d[i] = tx_buf_q[i];
    end
    if (ld_valid && w_accepting && w_ld_in_range) begin
      tx_buf_d[ld_addr] = ld_data;
    end
  end

  always_ff @(posedge axi_clk) begin
    for (int i = 0; i < INP_DEPTH; i++) begin
      tx_buf_q[i] <= tx_buf_d[i];
    end
  end

  // --------------------------------------------------------------------------
  // Receive buffer: cleared by reset, otherwise holds the last frame's results
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < OUT_DEPTH; i++) begin
      rx_buf_d[i] = rx_buf_q[i];
    end
    if (w_rx_beat) begin
      rx_buf_d[rx_idx_q] = s_axis_data;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        rx_buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        rx_buf_q[i] <= rx_buf_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are pure decodes of registered state, so valid/data stay stable
  // while the sink stalls.
  // --------------------------------------------------------------------------
  assign busy         = (state_q == S_SEND) || (state_q == S_RECV);
  assign done         = (state_q == S_DONE);
  assign m_axis_valid = (state_q == S_SEND);
  assign m_axis_data  = tx_buf_q[tx_idx_q];
  assign s_axis_ready = (state_q == S_RECV);
  assign res_data     = w_res_in_range ? rx_buf_q[res_addr] : '0;

`ifdef AXIS_FRAME_DRIVER_LAST_EN
  assign m_axis_last  = (state_q == S_SEND) && (tx_idx_q == C_TX_LAST);
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_frame_driver
//  Purpose  : Self-checking bench for axis_frame_driver. The main instance
//             uses default parameters. A second instance with OUT_DEPTH=3
//             shares all inputs and gives res_addr values beyond the depth.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_frame_driver;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        start = 1'b0;
  logic        m_axis_ready = 1'b0;
  logic        s_axis_valid = 1'b0;
  logic [34:0] s_axis_data = '0;
  logic        res_addr = 1'b0;
  logic [1:0]  res_addr_odd = '0;

  logic        busy, done, m_axis_valid, s_axis_ready;
  logic [31:0] m_axis_data;
  logic [34:0] res_data;
  logic        busy_odd, done_odd, m_axis_valid_odd, s_axis_ready_odd;
  logic [31:0] m_axis_data_odd;
  logic [34:0] res_data_odd;
`ifdef AXIS_FRAME_DRIVER_LAST_EN
  logic        m_axis_last, m_axis_last_odd;
`endif

  always #5 axi_clk = ~axi_clk;

  axis_frame_driver u_dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
`ifdef AXIS_FRAME_DRIVER_LAST_EN
    .m_axis_last  (m_axis_last),
`endif
    .m_axis_ready (m_axis_ready),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_ready (s_axis_ready),
    .res_addr     (res_addr),
    .res_data     (res_data)
  );

  axis_frame_driver #(.OUT_DEPTH(3)) u_dut_odd (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .start        (start),
    .busy         (busy_odd),
    .done         (done_odd),
    .m_axis_valid (m_axis_valid_odd),
    .m_axis_data  (m_axis_data_odd),
`ifdef AXIS_FRAME_DRIVER_LAST_EN
    .m_axis_last  (m_axis_last_odd),
`endif
    .m_axis_ready (m_axis_ready),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_ready (s_axis_ready_odd),
    .res_addr     (res_addr_odd),
    .res_data     (res_data_odd)
  );

  // Reference model: buffer contents as software sees them
  logic [31:0] tx_m   [8];
  logic [34:0] rx_m   [2];
  logic [34:0] rx_odd [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  function automatic logic [34:0] rand35();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[34:0];
  endfunction

  task automatic clear_rx_model();
    for (int i = 0; i < 2; i++) rx_m[i] = '0;
    for (int i = 0; i < 3; i++) rx_odd[i] = '0;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = 3'(a);
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
    tx_m[a]  = d;
  endtask

  // One complete frame, checked beat by beat against the model.
  // mode: 0 ready always high, 1 ready toggling 1010..., 2 random ready.
  task automatic run_frame(input int mode, input bit inject, input bit coload,
                           input bit consec, input bit fixed_res,
                           input logic [34:0] r0, input logic [34:0] r1);
    int beat, cyc, k;
    bit injected;
    logic [34:0] d;
    start = 1'b1;
    if (coload) begin
      ld_valid = 1'b1;
      ld_addr  = 3'd7;
      ld_data  = $urandom;
      tx_m[7]  = ld_data;
    end
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    beat = 0; cyc = 0; injected = 1'b0;
    while (beat < 8 && cyc < 200) begin
      case (mode)
        0:       m_axis_ready = 1'b1;
        1:       m_axis_ready = (cyc % 2 == 0);
        default: m_axis_ready = 1'($urandom_range(0, 1));
      endcase
      start = 1'b0; ld_valid = 1'b0; s_axis_valid = 1'b0;
      if (inject && !injected && beat == 1) begin
        // Everything here must be ignored while the frame is sending
        start = 1'b1; ld_valid = 1'b1; ld_addr = 3'd2; ld_data = 32'd99;
        s_axis_valid = 1'b1; s_axis_data = 35'h5A5A5;
        injected = 1'b1;
      end
      total_cnt++;
      if (m_axis_valid !== 1'b1 || m_axis_data !== tx_m[beat] || busy !== 1'b1)
        $display("FAIL send_beat%0d: valid=%b data=%h busy=%b, required valid=1 data=%h busy=1",
                 beat, m_axis_valid, m_axis_data, busy, tx_m[beat]);
      else pass_cnt++;
`ifdef AXIS_FRAME_DRIVER_LAST_EN
      total_cnt++;
      if (m_axis_last !== (beat == 7))
        $display("FAIL last_beat%0d: m_axis_last=%b required %b", beat, m_axis_last, (beat == 7));
      else pass_cnt++;
`endif
      if (m_axis_ready) beat++;
      cyc++;
      tick();
    end
    start = 1'b0; ld_valid = 1'b0; s_axis_valid = 1'b0; m_axis_ready = 1'b0;
    if (beat < 8) begin
      total_cnt++;
      $display("FAIL send_timeout: beats=%0d required 8", beat);
    end
    if (consec) begin
      total_cnt++;
      if (cyc !== 8) $display("FAIL send_consecutive: cycles=%0d required 8", cyc);
      else pass_cnt++;
    end
    total_cnt++;
    if (m_axis_valid !== 1'b0 || s_axis_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL to_recv: m_valid=%b s_ready=%b busy=%b, required 0 1 1",
               m_axis_valid, s_axis_ready, busy);
    else pass_cnt++;

    k = 0; cyc = 0;
    while (k < 2 && cyc < 200) begin
      s_axis_valid = ($urandom_range(0, 3) != 0);
      d = fixed_res ? ((k == 0) ? r0 : r1) : rand35();
      s_axis_data = d;
      total_cnt++;
      if (s_axis_ready !== 1'b1)
        $display("FAIL recv_ready: s_axis_ready=%b required 1", s_axis_ready);
      else pass_cnt++;
      if (s_axis_valid) begin
        rx_m[k]   = d;
        rx_odd[k] = d;
        k++;
      end
      cyc++;
      tick();
    end
    s_axis_valid = 1'b0;
    if (k < 2) begin
      total_cnt++;
      $display("FAIL recv_timeout: beats=%0d required 2", k);
    end
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || s_axis_ready !== 1'b0 || m_axis_valid !== 1'b0)
      $display("FAIL frame_done: done=%b busy=%b s_ready=%b m_valid=%b, required 1 0 0 0",
               done, busy, s_axis_ready, m_axis_valid);
    else pass_cnt++;

    // Extra beat: foreign to the main instance, last result for the odd one
    s_axis_valid = 1'b1;
    d = rand35();
    s_axis_data = d;
    rx_odd[2] = d;
    tick();
    s_axis_valid = 1'b0;
    total_cnt++;
    if (done_odd !== 1'b1 || done !== 1'b1)
      $display("FAIL odd_done: done_odd=%b done=%b required 1 1", done_odd, done);
    else pass_cnt++;

    for (int i = 0; i < 2; i++) begin
      res_addr = 1'(i);
      #1;
      total_cnt++;
      if (res_data !== rx_m[i])
        $display("FAIL res_data%0d: got %h required %h", i, res_data, rx_m[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    axi_reset_n = 1'b0;
    tick();
    tick();
    clear_rx_model();
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || m_axis_valid !== 1'b0 || s_axis_ready !== 1'b0)
      $display("FAIL reset_outputs: busy=%b done=%b m_valid=%b s_ready=%b required 0 0 0 0",
               busy, done, m_axis_valid, s_axis_ready);
    else pass_cnt++;
    axi_reset_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      res_addr = 1'(i);
      #1;
      total_cnt++;
      if (res_data !== 35'd0) $display("FAIL reset_res%0d: got %h required 0", i, res_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) load_word(i, 32'(i + 1));
    run_frame(0, 1'b0, 1'b0, 1'b1, 1'b1, 35'h10, 35'h7FFFFFFFF);
  endtask

  task automatic test_backpressure();
    run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_axis_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    m_axis_ready = 1'b0;
    axi_reset_n  = 1'b0;
    tick();
    clear_rx_model();
    total_cnt++;
    if (m_axis_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset: m_valid=%b done=%b busy=%b required 0 0 0",
               m_axis_valid, done, busy);
    else pass_cnt++;
    axi_reset_n = 1'b1;
    tick();
    // Transmit buffer survives reset, so the retransmission starts from word 1
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_ignore_in_send();
    run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      load_word($urandom_range(0, 6), $urandom);
      run_frame(2, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_result_range();
    for (int i = 0; i < 4; i++) begin
      res_addr_odd = 2'(i);
      #1;
      total_cnt++;
      if (res_data_odd !== ((i < 3) ? rx_odd[i] : 35'd0))
        $display("FAIL odd_res%0d: got %h required %h", i, res_data_odd,
                 (i < 3) ? rx_odd[i] : 35'd0);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tx_m[i] = '0;
    clear_rx_model();
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_frame();
    test_ignore_in_send();
    test_back_to_back();
    test_result_range();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_frame_driver.md
AXIS_FRAME_DRIVER -- requirements
Module: axis_frame_driver

Interface
REQ-001 SHALL have parameter INP_DEPTH, default 8: words per transmitted frame.
REQ-002 SHALL have parameter OUT_DEPTH, default 2: result words received per frame.
REQ-003 SHALL have parameter INPUT_DATA_WIDTH, default 32: transmitted word width.
REQ-004 SHALL have parameter OUTPUT_DATA_WIDTH, default INPUT_DATA_WIDTH+$clog2(INP_DEPTH) (35): received word width.
REQ-005 SHALL have port axi_clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port axi_reset_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port ld_valid  input  1  write tx_buf[ld_addr] with ld_data.
REQ-008 SHALL have port ld_addr  input  max(1,$clog2(INP_DEPTH))  tx buffer word index.
REQ-009 SHALL have port ld_data  input  INPUT_DATA_WIDTH  tx buffer write data.
REQ-010 SHALL have port start  input  1  single-cycle request to run one frame.
REQ-011 SHALL have port busy  output  1  high while sending or receiving.
REQ-012 SHALL have port done  output  1  high from frame completion until next start.
REQ-013 SHALL have port m_axis_valid  output  1  AXIS master valid.
REQ-014 SHALL have port m_axis_data  output  INPUT_DATA_WIDTH  AXIS master data.
REQ-015 SHALL have port m_axis_ready  input  1  AXIS master ready from sink.
REQ-016 SHALL have port s_axis_valid  input  1  AXIS slave valid from result source.
REQ-017 SHALL have port s_axis_data  input  OUTPUT_DATA_WIDTH  AXIS slave data, signed result.
REQ-018 SHALL have port s_axis_ready  output  1  AXIS slave ready.
REQ-019 SHALL have port res_addr  input  max(1,$clog2(OUT_DEPTH))  result readback index.
REQ-020 SHALL have port res_data  output  OUTPUT_DATA_WIDTH  rx_buf[res_addr], combinational; 0 if res_addr>=OUT_DEPTH.

Function
REQ-021 SHALL implement FSM IDLE, SEND, RECV, DONE; busy = SEND|RECV; done = DONE.
REQ-022 SHALL accept ld_valid writes only in IDLE/DONE; ignored in SEND/RECV; ld_addr>=INP_DEPTH ignored.
REQ-023 SHALL move IDLE/DONE -> SEND on start; tx_idx=0, rx_idx=0, done clears same edge; start in SEND/RECV ignored.
REQ-024 SHALL, if ld_valid and start coincide, commit the write and include it in the frame.
REQ-025 SHALL in SEND drive m_axis_valid=1, m_axis_data=tx_buf[tx_idx]; first beat offered cycle after start.
REQ-026 SHALL count a beat on m_axis_valid&m_axis_ready; tx_idx++; data/valid held stable while ready low.
REQ-027 SHALL move SEND -> RECV on beat INP_DEPTH-1; m_axis_valid low and s_axis_ready high from next cycle.
REQ-028 SHALL in RECV drive s_axis_ready=1; each s_axis_valid beat writes rx_buf[rx_idx], rx_idx++.
REQ-029 SHALL move RECV -> DONE on beat OUT_DEPTH-1; s_axis_ready low from next cycle.
REQ-030 SHALL hold s_axis_ready=0 outside RECV (foreign beats dropped) and m_axis_valid=0 outside SEND.
REQ-031 SHALL keep rx_buf contents through DONE and IDLE until overwritten by a later frame.

Reset
REQ-032 SHALL on axi_reset_n=0 at clock edge: state=IDLE, tx_idx=rx_idx=0, rx_buf=0, m_axis_valid=s_axis_ready=busy=done=0; tx_buf not reset.
REQ-033 SHALL abandon any frame on reset mid-SEND/RECV; next start retransmits from word 0.

Configuration
REQ-034 SHALL, with macro AXIS_FRAME_DRIVER_LAST_EN defined, add output m_axis_last (1 bit), high only with word INP_DEPTH-1 while m_axis_valid.
REQ-035 SHALL, without AXIS_FRAME_DRIVER_LAST_EN, omit m_axis_last; all other behaviour identical.

Verification
REQ-036 SHALL test: load words 1..8, start, m_axis_ready=1 -> data 1..8 on 8 consecutive cycles, then s_axis_ready=1; send 35'h10, 35'h7FFFFFFFF -> done=1, res_data(0)=35'h10, res_data(1)=35'h7FFFFFFFF.
REQ-037 SHALL test: m_axis_ready toggling 1010... -> each word held until accepted, exactly 8 beats, order 1..8.
REQ-038 SHALL test: reset asserted after 3 beats -> m_axis_valid=0 next cycle, done=0; new start sends word 1 first.
REQ-039 SHALL test: start and ld_valid(addr 2, data 99) in SEND, s_axis_valid in SEND -> all ignored, frame unchanged, no result captured.
REQ-040 SHALL test: with AXIS_FRAME_DRIVER_LAST_EN, m_axis_last=1 only on 8th beat; res_addr=3 -> res_data=0.
